// File: rtl/lmsm_sequencer_if.sv
// Controller/memory-side bundle of the LM/SM sequencer: launch request, memory
// handshake and datapath strobes. The master side drives the launch fields and mem_ready.
interface lmsm_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned IDX_W  = 3
);
  logic              start;
  logic              is_store;
  logic [NREG-1:0]   reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  reg_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic              rf_rd;
  logic              regw;
  logic [3:0]        count;

  modport master (
    output start, is_store, reg_mask, base_addr, mem_ready,
    input  busy, done, reg_idx, mem_addr, mem_req, mem_we, rf_rd, regw, count
  );

  modport slave (
    input  start, is_store, reg_mask, base_addr, mem_ready,
    output busy, done, reg_idx, mem_addr, mem_req, mem_we, rf_rd, regw, count
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks the latched register mask from R0
// upward, issuing one handshaked memory transfer per set bit, then pulses done.
module lmsm_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset_pin,
  lmsm_sequencer_if.slave   bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              store_q, store_d;
  logic [3:0]        count_q, count_d;
  logic [NREG-1:0]   low_bit;
  logic [IDX_W-1:0]  idx;

  // Isolate the lowest pending bit; it is the one retired by the current transfer.
  assign low_bit = mask_q & (~mask_q + NREG'(1));

  // Priority encoder: lowest set bit wins (R0 highest priority).
  always_comb begin
    idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  // Next-state: launch latching, per-transfer retirement and completion.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    store_d = store_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mask_d  = bus.reg_mask;
          addr_d  = bus.base_addr;
          store_d = bus.is_store;
          count_d = 4'd0;
          state_d = (bus.reg_mask == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (bus.mem_ready) begin
          mask_d  = mask_q & ~low_bit;
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q + 4'd1;
          if ((mask_q & ~low_bit) == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any sequence silently.
  always_ff @(posedge clk) begin
    if (reset_pin) begin
      state_q <= StIdle;
      mask_q  <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      count_q <= count_d;
    end
  end

  // Outputs decoded from state; regw is the only one that also depends on mem_ready.
  always_comb begin
    bus.busy     = (state_q == StIssue);
    bus.mem_req  = (state_q == StIssue);
    bus.mem_we   = (state_q == StIssue) & store_q;
    bus.rf_rd    = (state_q == StIssue) & store_q;
    bus.regw     = (state_q == StIssue) & bus.mem_ready & ~store_q;
    bus.done     = (state_q == StDone);
    bus.reg_idx  = idx;
    bus.mem_addr = addr_q;
    bus.count    = count_q;
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: the driver pushes the expected transfer list
// and done record per launch; a negedge monitor pops and compares as the DUT responds.
module tb_lmsm_sequencer;

  typedef struct {
    bit is_done;
    int idx;
    int addr;
    bit st;
    int cnt;
    int ecyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_pin = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  lmsm_sequencer_if #(.ADDR_W(16), .NREG(8), .IDX_W(3)) bus ();

  lmsm_sequencer #(.ADDR_W(16), .NREG(8), .IDX_W(3)) dut (
    .clk       (clk),
    .reset_pin (reset_pin),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: one transfer per set bit, ascending, consecutive 16-bit addresses.
  function automatic int push_expected(bit st, logic [7:0] mask, logic [15:0] base,
                                       int t0, bit timed, int done_lat);
    exp_t e;
    int   k;
    logic [15:0] a;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        a = base + 16'(k);
        e.is_done = 1'b0; e.idx = i; e.addr = int'(a); e.st = st; e.cnt = 0;
        e.ecyc = timed ? t0 + k + 1 : -1;
        sb.push_back(e);
        k++;
      end
    end
    e.is_done = 1'b1; e.idx = 0; e.addr = 0; e.st = st; e.cnt = k;
    e.ecyc = timed ? t0 + k + 1 : ((done_lat >= 0) ? t0 + done_lat : -1);
    sb.push_back(e);
    return k;
  endfunction

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_pin) begin
      chk("busy_eq_req", int'(bus.busy), int'(bus.mem_req));
      chk("strobe_outside_issue",
          int'((bus.regw && !(bus.mem_req && bus.mem_ready)) || (bus.mem_we && !bus.mem_req)),
          0);
      if (bus.mem_req) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = sb[0];
          chk("reg_idx", int'(bus.reg_idx), e.idx);
          chk("mem_addr", int'(bus.mem_addr), e.addr);
          chk("mem_we", int'(bus.mem_we), int'(e.st));
          chk("rf_rd", int'(bus.rf_rd), int'(e.st));
          chk("regw", int'(bus.regw), int'(bus.mem_ready && !e.st));
          if (bus.mem_ready) begin
            if (e.ecyc >= 0) chk("xfer_cycle", cyc, e.ecyc);
            void'(sb.pop_front());
          end
        end
      end
      if (bus.done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_count", int'(bus.count), e.cnt);
          if (e.ecyc >= 0) chk("done_cycle", cyc, e.ecyc);
        end
      end
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_idx"}, int'(bus.reg_idx), 0);
    chk({tag, "_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_req"}, int'(bus.mem_req), 0);
    chk({tag, "_we"}, int'(bus.mem_we), 0);
    chk({tag, "_rfrd"}, int'(bus.rf_rd), 0);
    chk({tag, "_regw"}, int'(bus.regw), 0);
    chk({tag, "_count"}, int'(bus.count), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles then high.
  task automatic run_seq(bit st, logic [7:0] mask, logic [15:0] base, int mode,
                         bit protect, int done_lat);
    int n;
    int t0;
    int nbits;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.is_store = st;
    bus.reg_mask = mask;
    bus.base_addr = base;
    bus.mem_ready = (mode == 0) ? 1'b1 : 1'($urandom);
    t0 = cyc;
    nbits = push_expected(st, mask, base, t0, mode == 0, done_lat);
    @(posedge clk); #1;
    bus.start = protect;
    bus.reg_mask = 8'($urandom);
    bus.base_addr = 16'($urandom);
    bus.is_store = 1'($urandom);
    n = 0;
    while (!bus.done && n < 300) begin
      case (mode)
        0:       bus.mem_ready = 1'b1;
        1:       bus.mem_ready = ($urandom_range(2) != 0);
        default: bus.mem_ready = (n >= 3);
      endcase
      if (protect) bus.start = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    bus.mem_ready = 1'($urandom);
    if (n >= 300) begin
      chk("done_timeout", 0, 1);
      reset_pin = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      reset_pin = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("count_hold", int'(bus.count), nbits);
      chk("done_one_cycle", int'(bus.done), 0);
      chk("idle_req", int'(bus.mem_req), 0);
    end
  endtask

  initial begin
    logic [7:0]  m;
    logic [15:0] b;
    int          nb;
    bus.start = 1'b0;
    bus.is_store = 1'b0;
    bus.reg_mask = '0;
    bus.base_addr = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_pin = 1'b0;

    run_seq(1'b0, 8'h05, 16'h0100, 0, 1'b0, -1);
    run_seq(1'b1, 8'h80, 16'h0200, 2, 1'b0, 5);
    run_seq(1'b0, 8'h00, 16'h1234, 0, 1'b0, -1);
    run_seq(1'b0, 8'h03, 16'hFFFF, 0, 1'b0, -1);
    run_seq(1'b0, 8'hFF, 16'h0010, 0, 1'b0, -1);

    // Abort: reset during the second transfer of a 4-bit load.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.is_store = 1'b0;
    bus.reg_mask = 8'h0F;
    bus.base_addr = 16'h0300;
    bus.mem_ready = 1'b1;
    nb = push_expected(1'b0, 8'h0F, 16'h0300, cyc, 1'b1, -1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset_pin = 1'b1;
    @(posedge clk); #1;
    check_all_zero("abort");
    chk("abort_pending", sb.size(), nb);
    sb.delete();
    reset_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_seq(1'b0, 8'h21, 16'h0400, 0, 1'b0, -1);
    run_seq(1'b1, 8'h0F, 16'h0500, 0, 1'b1, -1);
    run_seq(1'b0, 8'h3C, 16'h0600, 1, 1'b1, -1);

    for (int r = 0; r < 40; r++) begin
      m = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      b = ($urandom_range(3) == 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom);
      run_seq(1'($urandom), m, b, int'($urandom_range(1)), 1'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
